fxyz_sweep: RTL and testbench

Sequencer that exhaustively exercises a 3-input combinational function block (such as `fxyz`) in hardware. It applies all 8 input vectors in order, waits a programmable settle time per vector, and samples the function output into an 8-bit truth table. It then compares the table against an expected mask captured at start. It sits beside the function block on the lab board and replaces the hand-written `#1` stimulus sequence with a clocked, repeatable sweep.

---
 rtl/fxyz_sweep_pkg.sv | 19 +
 rtl/fxyz_sweep_first_diff8.sv | 27 ++
 rtl/fxyz_sweep.sv | 147 ++++++++++++++
 tb/tb_fxyz_sweep.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fxyz_sweep_pkg.sv
// fxyz_sweep_pkg
//   Shared types and sizes for the fxyz truth-table sweeper.
//   N_IN  : number of inputs of the swept function block
//   N_VEC : number of input vectors applied per sweep (2**N_IN)
//   CNT_W : width of the settle counter (covers SETTLE_CYC up to 15)
package fxyz_sweep_pkg;

    localparam int N_IN  = 3;
    localparam int N_VEC = 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/fxyz_sweep_first_diff8.sv
// first_diff8
//   Combinational lowest-set-bit encoder for an 8-bit difference vector.
//   Ports:
//     diff  in  8  table ^ expected
//     idx   out 3  index of the lowest set bit (0 when none set)
//     any   out 1  at least one bit of diff is set
module first_diff8
    import fxyz_sweep_pkg::*;
(
    input  logic [N_VEC-1:0] diff,
    output logic [N_IN-1:0]  idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // First hit while scanning upward wins, giving the lowest index.
        for (int unsigned i = 0; i < N_VEC; i++) begin
            if (diff[i] && !any) begin
                idx = N_IN'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fxyz_sweep.sv
// fxyz_sweep
//   Clocked sweeper for a 3-input combinational function block. Drives all
//   8 input vectors in order, holds each SETTLE_CYC+1 cycles, samples the
//   block output into an 8-bit truth table and compares it with an
//   expected mask captured when the sweep is accepted.
//   Parameter:
//     SETTLE_CYC  cycles per vector before the sample cycle (1..15)
//   Ports:
//     clk       in   clock, rising edge
//     reset     in   asynchronous active-high reset
//     start     in   sweep request, accepted only when idle
//     expected  in 8 expected truth table (bit i = output for vector i)
//     s         in   function block output
//     x, y, z   out  vector to the function block ({x,y,z} = index)
//     busy      out  sweep in progress (accept edge until DONE is left)
//     done      out  one-cycle result-valid pulse
//     table_o   out 8 sampled truth table
//     mismatch  out  table_o differs from the captured expectation
//     err_idx   out 3 lowest differing vector index (0 if none)
module fxyz_sweep
    import fxyz_sweep_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       s,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_o,
    output logic       mismatch,
    output logic [2:0] err_idx
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(N_VEC - 1);

    sweep_state_t     state;
    sweep_state_t     state_nxt;
    logic [N_IN-1:0]  idx;
    logic [CNT_W-1:0] cnt;
    logic [N_VEC-1:0] exp_q;
    logic [N_VEC-1:0] table_nxt;
    logic [N_IN-1:0]  diff_idx;
    logic             diff_any;
    logic             accept;
    logic             sample_en;
    logic             last_vec;

    assign {x, y, z} = idx;
    assign last_vec  = (idx == IDX_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample_en = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                sample_en = 1'b1;
                state_nxt = last_vec ? DONE : SETTLE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Table as it will be after this cycle's sample, so the final compare
    // can be registered on the same edge that enters DONE.
    always_comb begin
        table_nxt      = table_o;
        table_nxt[idx] = s;
    end

    first_diff8 u_first_diff8 (
        .diff (table_nxt ^ exp_q),
        .idx  (diff_idx),
        .any  (diff_any)
    );

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx      <= '0;
            cnt      <= '0;
            exp_q    <= '0;
            table_o  <= '0;
            mismatch <= 1'b0;
            err_idx  <= '0;
        end else if (accept) begin
            idx      <= '0;
            cnt      <= '0;
            exp_q    <= expected;
            table_o  <= '0;
            mismatch <= 1'b0;
            err_idx  <= '0;
        end else begin
            if (state == SETTLE) begin
                cnt <= cnt + 1'b1;
            end
            if (sample_en) begin
                table_o <= table_nxt;
                if (last_vec) begin
                    mismatch <= diff_any;
                    err_idx  <= diff_idx;
                end else begin
                    idx <= idx + 1'b1;
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fxyz_sweep.sv
// tb_fxyz_sweep
//   Directed bench for fxyz_sweep. u_dut1 (SETTLE_CYC=1) sweeps the fxyz
//   block s = x & y & ~z (truth table 8'h40); u_dut3 (SETTLE_CYC=3) sweeps
//   s = x (truth table 8'hF0).
module tb_fxyz_sweep;

    logic       clk = 1'b0;
    logic       reset;

    logic       start1;
    logic [7:0] exp1;
    logic       s1, x1, y1, z1, busy1, done1, mis1;
    logic [7:0] table1;
    logic [2:0] err1;

    logic       start3;
    logic [7:0] exp3;
    logic       s3, x3, y3, z3, busy3, done3, mis3;
    logic [7:0] table3;
    logic [2:0] err3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign s1 = x1 & y1 & ~z1;
    assign s3 = x3;

    fxyz_sweep #(.SETTLE_CYC(1)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start1),
        .expected (exp1),
        .s        (s1),
        .x        (x1),
        .y        (y1),
        .z        (z1),
        .busy     (busy1),
        .done     (done1),
        .table_o  (table1),
        .mismatch (mis1),
        .err_idx  (err1)
    );

    fxyz_sweep #(.SETTLE_CYC(3)) u_dut3 (
        .clk      (clk),
        .reset    (reset),
        .start    (start3),
        .expected (exp3),
        .s        (s3),
        .x        (x3),
        .y        (y3),
        .z        (z3),
        .busy     (busy3),
        .done     (done3),
        .table_o  (table3),
        .mismatch (mis3),
        .err_idx  (err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // One sweep on u_dut1, observed for 60 cycles after the accept edge.
    // mode 0: plain; 1: stray start pulses incl. on the done cycle;
    // 2: start held until the second done; 3: expected toggled mid-sweep.
    task automatic run1(input logic [7:0] e, input int mode,
                        output int d1, output int d2, output int nd,
                        output logic [7:0] t_d, output logic m_d, output logic [2:0] ei_d);
        d1 = -1; d2 = -1; nd = 0; t_d = '0; m_d = 1'b0; ei_d = '0;
        @(posedge clk); #1;
        exp1   = e;
        start1 = 1'b1;
        @(posedge clk); #1;              // accept edge E0 just passed
        if (mode != 2) start1 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;          // just after edge E0+k
            if (mode != 2) start1 = 1'b0;
            if (mode == 3 && k == 5)  exp1 = ~e;
            if (mode == 3 && k == 10) exp1 = 8'h00;
            if (done1) begin
                nd++;
                if (nd == 1) begin
                    d1   = k;
                    t_d  = table1;
                    m_d  = mis1;
                    ei_d = err1;
                    if (mode == 1) start1 = 1'b1;
                end else if (nd == 2) begin
                    d2 = k;
                    if (mode == 2) start1 = 1'b0;
                end
            end
            if (mode == 1 && (k == 3 || k == 7 || k == 11)) start1 = 1'b1;
        end
        start1 = 1'b0;
    endtask

    initial begin
        int d1, d2, nd, bad, kd, ndone;
        logic [7:0] t_d;
        logic       m_d;
        logic [2:0] ei_d;

        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        exp1   = 8'h00;
        exp3   = 8'h00;

        // Reset values
        #12;
        check("rst_xyz",   {29'd0, x1, y1, z1}, 32'd0);
        check("rst_busy",  {31'd0, busy1}, 32'd0);
        check("rst_done",  {31'd0, done1}, 32'd0);
        check("rst_table", {24'd0, table1}, 32'h00);
        check("rst_mis",   {31'd0, mis1}, 32'd0);
        check("rst_err",   {29'd0, err1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Matching sweep
        run1(8'h40, 0, d1, d2, nd, t_d, m_d, ei_d);
        check("m40_done_cyc", d1, 32'd16);
        check("m40_ndone",    nd, 32'd1);
        check("m40_table",    {24'd0, t_d}, 32'h40);
        check("m40_mis",      {31'd0, m_d}, 32'd0);
        check("m40_err",      {29'd0, ei_d}, 32'd0);
        check("m40_busy_end", {31'd0, busy1}, 32'd0);
        check("m40_idx_held", {29'd0, x1, y1, z1}, 32'd7);

        // Mismatch at vector 0, held after done
        run1(8'h41, 0, d1, d2, nd, t_d, m_d, ei_d);
        check("m41_table", {24'd0, t_d}, 32'h40);
        check("m41_mis",   {31'd0, m_d}, 32'd1);
        check("m41_err",   {29'd0, ei_d}, 32'd0);
        check("m41_mis_held", {31'd0, mis1}, 32'd1);

        // Mismatch at vector 7
        run1(8'hC0, 0, d1, d2, nd, t_d, m_d, ei_d);
        check("mC0_table", {24'd0, t_d}, 32'h40);
        check("mC0_mis",   {31'd0, m_d}, 32'd1);
        check("mC0_err",   {29'd0, ei_d}, 32'd7);
        check("mC0_err_held", {29'd0, err1}, 32'd7);

        // SETTLE_CYC=3 with s = x: each vector held 4 cycles, done at E0+32
        @(posedge clk); #1;
        exp3   = 8'hF0;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        bad = 0;
        kd  = -1;
        if ({x3, y3, z3} != 3'd0) bad++;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (k <= 32 && {29'd0, x3, y3, z3} != ((k / 4 > 7) ? 7 : k / 4)) bad++;
            if (done3 && kd < 0) begin
                kd = k;
                check("s3_table", {24'd0, table3}, 32'hF0);
                check("s3_mis",   {31'd0, mis3}, 32'd0);
            end
        end
        check("s3_vec_timing", bad, 32'd0);
        check("s3_done_cyc",   kd, 32'd32);

        // Reset during vector 4: asynchronous abort, no done
        @(posedge clk); #1;
        exp1   = 8'h40;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
        end
        check("ra_vec4", {29'd0, x1, y1, z1}, 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check("ra_xyz",   {29'd0, x1, y1, z1}, 32'd0);
        check("ra_busy",  {31'd0, busy1}, 32'd0);
        check("ra_table", {24'd0, table1}, 32'h00);
        check("ra_done",  {31'd0, done1}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        check("ra_no_done", ndone, 32'd0);
        run1(8'h40, 0, d1, d2, nd, t_d, m_d, ei_d);
        check("ra_clean_table", {24'd0, t_d}, 32'h40);
        check("ra_clean_done",  d1, 32'd16);

        // Stray start pulses, including on the done cycle
        run1(8'h40, 1, d1, d2, nd, t_d, m_d, ei_d);
        check("sp_done_cyc", d1, 32'd16);
        check("sp_ndone",    nd, 32'd1);
        check("sp_busy_end", {31'd0, busy1}, 32'd0);

        // Start held: back-to-back sweeps with one idle cycle between
        run1(8'h40, 2, d1, d2, nd, t_d, m_d, ei_d);
        check("sh_done1", d1, 32'd16);
        check("sh_done2", d2, 32'd34);
        check("sh_ndone", nd, 32'd2);
        check("sh_busy_end", {31'd0, busy1}, 32'd0);

        // expected changed mid-sweep has no effect
        run1(8'h40, 3, d1, d2, nd, t_d, m_d, ei_d);
        check("et_table", {24'd0, t_d}, 32'h40);
        check("et_mis",   {31'd0, m_d}, 32'd0);
        check("et_err",   {29'd0, ei_d}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
